// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared geometry, address field positions and FSM state for the data cache
package dcache_ctrl_pkg;

    localparam int DC_IDX_W   = 4;
    localparam int DC_LINE_W  = 256;
    localparam int DC_ADDR_W  = 32;

    // 32-byte lines of 32-bit words: bits [4:2] pick the word, [1:0] are ignored
    localparam int OFF_W      = 5;
    localparam int WORD_LSB   = 2;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data arrays: async read, sync word write and line fill
module dcache_sram
    import dcache_ctrl_pkg::*;
#(
    parameter int IDX_W  = DC_IDX_W,
    parameter int TAG_W  = DC_ADDR_W - OFF_W - DC_IDX_W,
    parameter int LINE_W = DC_LINE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [TAG_W-1:0]      tag_o,
    output logic                  valid_o,
    output logic                  dirty_o,
    output logic [LINE_W-1:0]     line_o,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_wdata_i,
    input  logic                  fill_we_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [LINE_W-1:0]     fill_line_i
);

    localparam int NLINES = 1 << IDX_W;

    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [LINE_W-1:0] data_q [NLINES];
    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid gates every use of them
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0} +: WORD_W] <= word_wdata_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back data cache controller for the memory stage
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int IDX_W  = DC_IDX_W,
    parameter int LINE_W = DC_LINE_W,
    parameter int ADDR_W = DC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              MemStall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    state_e state_q, state_d;
    logic   ack_q, ack_d;

    logic                  req;
    logic                  is_write;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] word_sel;

    logic [TAG_W-1:0]  arr_tag;
    logic              arr_valid;
    logic              arr_dirty;
    logic [LINE_W-1:0] arr_line;
    logic              word_we;
    logic              fill_we;

    logic unused_byte_off;
    assign unused_byte_off = ^addr_i[WORD_LSB-1:0];

    assign idx      = addr_i[OFF_W +: IDX_W];
    assign tag      = addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel = addr_i[WORD_LSB +: WORD_SEL_W];
    assign req      = MemRead_i | MemWrite_i;
    assign is_write = MemWrite_i;
    assign hit      = arr_valid && (arr_tag == tag);

    dcache_sram #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .idx_i        (idx),
        .tag_o        (arr_tag),
        .valid_o      (arr_valid),
        .dirty_o      (arr_dirty),
        .line_o       (arr_line),
        .word_we_i    (word_we),
        .word_sel_i   (word_sel),
        .word_wdata_i (wdata_i),
        .fill_we_i    (fill_we),
        .fill_tag_i   (tag),
        .fill_line_i  (mem_rdata_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // ack_q forces mem_req_o low for one cycle after every ack, so a refill that
    // follows a write-back presents memory with a fresh rising request.
    always_comb begin
        state_d     = state_q;
        rdata_o     = '0;
        MemStall_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        word_we     = 1'b0;
        fill_we     = 1'b0;
        ack_d       = 1'b0;

        if (rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            word_we = is_write;
                            if (!is_write) begin
                                rdata_o = arr_line[{word_sel, 5'b0} +: WORD_W];
                            end
                        end else begin
                            MemStall_o = 1'b1;
                            state_d    = (arr_valid && arr_dirty) ? ST_WRITEBACK : ST_REFILL;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    MemStall_o  = 1'b1;
                    mem_req_o   = !ack_q;
                    mem_write_o = 1'b1;
                    mem_addr_o  = {arr_tag, idx, {OFF_W{1'b0}}};
                    mem_wdata_o = arr_line;
                    if (mem_ack_i && !ack_q) begin
                        ack_d   = 1'b1;
                        state_d = ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    MemStall_o = 1'b1;
                    mem_req_o  = !ack_q;
                    mem_addr_o = {tag, idx, {OFF_W{1'b0}}};
                    if (mem_ack_i && !ack_q) begin
                        ack_d   = 1'b1;
                        fill_we = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule
